mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports RegWriteE, MemtoRegE, MemWriteE, PCSrcE  in  1 each  execute-stage controls.
REQ-004 SHALL have ports RdE  in  4  destination register; ALUResultE, WriteDataE  in  32 each  address/ALU result and store data.
REQ-005 SHALL have ports RegWriteM, PCSrcM  out  1; RdM  out  4; ALUResultM  out  32  M-stage contents, for forwarding and hazard logic.
REQ-006 SHALL have ports MemReq, MemWe  out  1; MemAddr, MemWData  out  32  data-memory request bus.
REQ-007 SHALL have ports MemReady  in  1; MemRData  in  32  data-memory response.
REQ-008 SHALL have port StallM  out  1  to hazard unit: hold F/D/E stages.
REQ-009 SHALL have ports RegWriteW, MemtoRegW, PCSrcW  out  1; RdW  out  4; ReadDataW, ALUResultW  out  32  writeback-stage register.
REQ-010 SHALL have port MemErr  out  1  sticky timeout error.
REQ-011 SHALL have port WaitCnt  out  8  saturating count of wait cycles of current access.

Function
REQ-012 M register (E->M controls, RdE, ALUResultE, WriteDataE) SHALL load on rising clk when StallM=0 and hold when StallM=1.
REQ-013 A memory op SHALL be defined as MemWriteM=1 or MemtoRegM=1 in the M register.
REQ-014 FSM SHALL have states IDLE, WAIT, ERR; reset state IDLE.
REQ-015 MemReq SHALL be combinational: 1 when a memory op is in M and state is IDLE or WAIT; 0 in ERR.
REQ-016 MemWe SHALL equal MemReq AND MemWriteM; MemAddr SHALL equal ALUResultM; MemWData SHALL equal WriteDataM.
REQ-017 Completion SHALL be any cycle with MemReq=1 and MemReady=1; zero-wait completion in IDLE is legal.
REQ-018 StallM SHALL equal MemReq AND NOT MemReady, OR state=ERR.
REQ-019 IDLE->WAIT when MemReq=1 and MemReady=0; WAIT->IDLE on completion; WAIT->ERR when WaitCnt=255 and MemReady=0; ERR is left only by reset.
REQ-020 WaitCnt SHALL clear on entry to IDLE, increment each WAIT cycle without completion, saturate at 255.
REQ-021 MemAddr, MemWData, MemWe SHALL stay stable while in WAIT (guaranteed by REQ-012 hold).
REQ-022 W register SHALL load M contents plus ReadDataW<=MemRData when StallM=0; when StallM=1 it SHALL load a bubble (RegWriteW=0, PCSrcW=0, other W fields hold).
REQ-023 ReadDataW SHALL capture MemRData only on the completion cycle of a load; for non-loads it SHALL hold.
REQ-024 Non-memory ops SHALL pass M->W in 1 cycle with no MemReq; memory ops SHALL pass in 1 + wait cycles.
REQ-025 MemErr SHALL be 1 exactly while state=ERR; in ERR no register writes escape (W gets bubbles).
REQ-026 MemReady while MemReq=0 SHALL be ignored.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) clear all M and W registers to 0, state to IDLE, WaitCnt to 0, MemErr to 0; MemReq, MemWe, StallM therefore 0.
REQ-028 reset asserted mid-WAIT SHALL abandon the access with no W write; after release the first instruction SHALL be taken fresh from E.

Verification
REQ-029 ALU op (RegWriteE=1, RdE=3, ALUResultE=0x10): one cycle later RdM=3, ALUResultM=0x10, MemReq=0; next cycle RegWriteW=1, RdW=3, ALUResultW=0x10.
REQ-030 Load addr 0x100, MemReady=1 same cycle, MemRData=0xDEADBEEF: MemReq=1, StallM=0, next cycle ReadDataW=0xDEADBEEF, MemtoRegW=1.
REQ-031 Store addr 0x200 data 0x55, MemReady low 3 cycles: MemReq=MemWe=1 and StallM=1 for 3 cycles, MemAddr/MemWData stable, RegWriteW=0 bubbles, WaitCnt reaches 3, then completes, WaitCnt back to 0.
REQ-032 Load with MemReady held 0: after 256 wait cycles state ERR, MemErr=1, MemReq=0, StallM=1; reset=0 clears MemErr.
REQ-033 reset=0 pulsed during WAIT with new E data pending: MemReq drops in same cycle, no W write, after release E data enters M normally.

Source files
------------

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  mem_stage : pipeline M/W stage with a handshaked data-memory port,
//              wait-state stall, saturating wait counter and sticky timeout.
//  Rev 1.0
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic        PCSrcE,
    input  logic [3:0]  RdE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    output logic        RegWriteM,
    output logic        PCSrcM,
    output logic [3:0]  RdM,
    output logic [31:0] ALUResultM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic [3:0]  RdW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic        MemErr,
    output logic [7:0]  WaitCnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] c_WAIT_MAX = 8'd255;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;

    logic        r_reg_write_m, r_mem_to_reg_m, r_mem_write_m, r_pcsrc_m;
    logic [3:0]  r_rd_m;
    logic [31:0] r_alu_m, r_wdata_m;

    logic        r_reg_write_w, r_mem_to_reg_w, r_pcsrc_w;
    logic [3:0]  r_rd_w;
    logic [31:0] r_alu_w, r_rdata_w;

    logic        w_mem_op, w_mem_req, w_done, w_stall;

    always_comb begin
        w_mem_op  = r_mem_write_m | r_mem_to_reg_m;
        w_mem_req = w_mem_op & (r_state != ST_ERR);
        w_done    = w_mem_req & MemReady;
        w_stall   = (w_mem_req & ~MemReady) | (r_state == ST_ERR);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_req && !MemReady) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_done)
                    w_state_nxt = ST_IDLE;
                else if (r_wait_cnt == c_WAIT_MAX)
                    w_state_nxt = ST_ERR;
            end
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_IDLE)
                r_wait_cnt <= 8'd0;
            else if (w_mem_req && !MemReady && (r_wait_cnt != c_WAIT_MAX))
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // M holds while stalled so the memory request stays stable across waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_pcsrc_m      <= 1'b0;
            r_rd_m         <= 4'd0;
            r_alu_m        <= 32'd0;
            r_wdata_m      <= 32'd0;
        end else if (!w_stall) begin
            r_reg_write_m  <= RegWriteE;
            r_mem_to_reg_m <= MemtoRegE;
            r_mem_write_m  <= MemWriteE;
            r_pcsrc_m      <= PCSrcE;
            r_rd_m         <= RdE;
            r_alu_m        <= ALUResultE;
            r_wdata_m      <= WriteDataE;
        end
    end

    // While stalled W takes a bubble: only the side-effecting controls clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_reg_write_w  <= 1'b0;
            r_mem_to_reg_w <= 1'b0;
            r_pcsrc_w      <= 1'b0;
            r_rd_w         <= 4'd0;
            r_alu_w        <= 32'd0;
            r_rdata_w      <= 32'd0;
        end else if (w_stall) begin
            r_reg_write_w  <= 1'b0;
            r_pcsrc_w      <= 1'b0;
        end else begin
            r_reg_write_w  <= r_reg_write_m;
            r_mem_to_reg_w <= r_mem_to_reg_m;
            r_pcsrc_w      <= r_pcsrc_m;
            r_rd_w         <= r_rd_m;
            r_alu_w        <= r_alu_m;
            if (r_mem_to_reg_m)
                r_rdata_w  <= MemRData;
        end
    end

    assign RegWriteM  = r_reg_write_m;
    assign PCSrcM     = r_pcsrc_m;
    assign RdM        = r_rd_m;
    assign ALUResultM = r_alu_m;
    assign MemReq     = w_mem_req;
    assign MemWe      = w_mem_req & r_mem_write_m;
    assign MemAddr    = r_alu_m;
    assign MemWData   = r_wdata_m;
    assign StallM     = w_stall;
    assign RegWriteW  = r_reg_write_w;
    assign MemtoRegW  = r_mem_to_reg_w;
    assign PCSrcW     = r_pcsrc_w;
    assign RdW        = r_rd_w;
    assign ReadDataW  = r_rdata_w;
    assign ALUResultW = r_alu_w;
    assign MemErr     = (r_state == ST_ERR);
    assign WaitCnt    = r_wait_cnt;

endmodule
`default_nettype wire
